// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter types and constants: FSM encoding, master indices, timeout counter width,
// and a helper that sizes the round-robin pointer.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ERR  = 2'd2
  } arb_state_e;

  localparam int ARB_M_JTAG  = 0;
  localparam int ARB_M_UART  = 1;
  localparam int ARB_M_CPU_D = 2;
  localparam int ARB_M_CPU_I = 3;

  localparam int ARB_TO_W = 16;

  // Pointer width that stays legal for a single-master build.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational picker: first set request at or above 'start' (with wrap) becomes the one-hot winner.
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     winner
);

  logic [2*N-1:0] rot;
  logic [2*N-1:0] win_dbl;
  logic [N-1:0]   win_rot;
  logic           found;

  // Rotate requests so 'start' lands at bit 0, pick the lowest, rotate back.
  always_comb begin
    rot     = {req, req} >> start;
    win_rot = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        win_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    win_dbl = {win_rot, win_rot} << start;
    winner  = win_dbl[2*N-1:N];
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-transaction slave bus arbiter with timeout and CPU hold flag.
// Optional ARB_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                     NUM_MASTERS = 4,
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 32,
  parameter int                     TIMEOUT     = 255,
  parameter logic [NUM_MASTERS-1:0] CPU_MASK    = 4'b1100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_req_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic                          s_ack_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          hold_flag_o
);

  localparam int                  PTR_W   = ptr_w(NUM_MASTERS);
  localparam logic [ARB_TO_W-1:0] TO_LAST = ARB_TO_W'(TIMEOUT - 1);

  arb_state_e             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [ARB_TO_W-1:0]    cnt_reg, cnt_next;
  logic [NUM_MASTERS-1:0] pick_winner;
  logic [PTR_W-1:0]       pick_start;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
    assign addr_arr[gi]  = m_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = m_wdata_i[gi*DATA_W +: DATA_W];
  end

  bus_arb_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (m_req_i),
    .start  (pick_start),
    .winner (pick_winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_reg, ptr_next;

  // Pointer moves to one past the master that just won.
  always_comb begin
    ptr_next = ptr_reg;
    if (state_reg == ARB_IDLE && |m_req_i) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (pick_winner[k]) ptr_next = PTR_W'((k + 1) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end

  assign pick_start = ptr_reg;
`else
  assign pick_start = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    s_req_o    = 1'b0;
    m_ack_o    = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    unique case (state_reg)
      ARB_IDLE: begin
        if (|m_req_i) begin
          grant_next = pick_winner;
          cnt_next   = '0;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        s_req_o = 1'b1;
        // An ack on the last allowed cycle still beats the timeout.
        if (s_ack_i) begin
          m_ack_o    = grant_reg;
          m_rdata_o  = s_rdata_i;
          grant_next = '0;
          state_next = ARB_IDLE;
        end else begin
          cnt_next = cnt_reg + ARB_TO_W'(1);
          if (cnt_reg == TO_LAST) state_next = ARB_ERR;
        end
      end
      ARB_ERR: begin
        m_ack_o    = grant_reg;
        m_err_o    = grant_reg;
        grant_next = '0;
        state_next = ARB_IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (state_reg == ARB_BUSY) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_reg[k]) begin
          s_we_o    = m_we_i[k];
          s_addr_o  = addr_arr[k];
          s_wdata_o = wdata_arr[k];
        end
      end
    end
  end

  assign grant_o     = grant_reg;
  assign hold_flag_o = |(grant_reg & ~CPU_MASK);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT=4); expectations follow ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   m_req, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]   m_ack, m_err;
  logic [DW-1:0]   m_rdata;
  logic            s_req, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;
  logic [NM-1:0]   grant;
  logic            hold;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NM-1:0] t6_exp [5];

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req),
    .m_we_i      (m_we),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_ack_o     (m_ack),
    .m_err_o     (m_err),
    .m_rdata_o   (m_rdata),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_ack_i     (s_ack),
    .s_rdata_i   (s_rdata),
    .grant_o     (grant),
    .hold_flag_o (hold)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
    t6_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    t6_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    #3;
    check_val("rst_grant", grant, 0);
    check_val("rst_sreq", s_req, 0);
    check_val("rst_hold", hold, 0);
    check_val("rst_ack", m_ack, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: m2 single read, ack in third BUSY cycle
    m_req = 4'b0100; m_we = 4'b0000; m_addr[2*AW +: AW] = 32'h1000_0004;
    mid();
    check_val("t1_idle_sreq", s_req, 0);
    cyc(); mid();
    check_val("t1_b1_sreq", s_req, 1);
    check_val("t1_b1_grant", grant, 4'b0100);
    check_val("t1_b1_addr", s_addr, 32'h1000_0004);
    check_val("t1_b1_we", s_we, 0);
    check_val("t1_b1_hold", hold, 0);
    cyc(); mid();
    check_val("t1_b2_sreq", s_req, 1);
    check_val("t1_b2_ack", m_ack, 0);
    cyc(); s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; mid();
    check_val("t1_b3_sreq", s_req, 1);
    check_val("t1_b3_ack", m_ack, 4'b0100);
    check_val("t1_b3_rdata", m_rdata, 32'hDEAD_BEEF);
    check_val("t1_b3_hold", hold, 0);
    cyc(); m_req = '0; s_ack = 1'b0; s_rdata = '0; mid();
    check_val("t1_end_sreq", s_req, 0);
    check_val("t1_end_ack", m_ack, 0);
    check_val("t1_end_grant", grant, 0);
    $display("txn t1: m2 read 0x10000004 -> 0xdeadbeef");

    // 2: m0 write and m3 read contend, zero-wait slave
    do_reset();
    m_req = 4'b1001; m_we = 4'b0001;
    m_addr[0 +: AW] = 32'h0000_1000; m_wdata[0 +: DW] = 32'hCAFE_0001;
    m_addr[3*AW +: AW] = 32'h0000_2000;
    s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
    mid();
    check_val("t2_idle_grant", grant, 0);
    cyc(); mid();
    check_val("t2_m0_grant", grant, 4'b0001);
    check_val("t2_m0_hold", hold, 1);
    check_val("t2_m0_we", s_we, 1);
    check_val("t2_m0_addr", s_addr, 32'h0000_1000);
    check_val("t2_m0_wdata", s_wdata, 32'hCAFE_0001);
    check_val("t2_m0_ack", m_ack, 4'b0001);
    cyc(); m_req = 4'b1000; mid();
    check_val("t2_bubble_grant", grant, 0);
    check_val("t2_bubble_sreq", s_req, 0);
    check_val("t2_bubble_hold", hold, 0);
    cyc(); mid();
    check_val("t2_m3_grant", grant, 4'b1000);
    check_val("t2_m3_hold", hold, 0);
    check_val("t2_m3_we", s_we, 0);
    check_val("t2_m3_ack", m_ack, 4'b1000);
    check_val("t2_m3_rdata", m_rdata, 32'h5555_AAAA);
    cyc(); m_req = '0; m_we = '0; s_ack = 1'b0; mid();
    check_val("t2_end_grant", grant, 0);
    $display("txn t2: m0 write then m3 read, one bubble between");

    // 3: m1 timeout after 4 BUSY cycles
    cyc(); m_req = 4'b0010; m_addr[AW +: AW] = 32'h0000_3000; s_rdata = 32'h1234_5678; mid();
    for (int b = 1; b <= 4; b++) begin
      cyc(); mid();
      check_val($sformatf("t3_b%0d_sreq", b), s_req, 1);
      check_val($sformatf("t3_b%0d_ack", b), m_ack, 0);
      check_val($sformatf("t3_b%0d_hold", b), hold, 1);
    end
    cyc(); mid();
    check_val("t3_err_sreq", s_req, 0);
    check_val("t3_err_ack", m_ack, 4'b0010);
    check_val("t3_err_err", m_err, 4'b0010);
    check_val("t3_err_rdata", m_rdata, 0);
    cyc(); m_req = '0; mid();
    check_val("t3_end_ack", m_ack, 0);
    check_val("t3_end_err", m_err, 0);
    check_val("t3_end_grant", grant, 0);
    $display("txn t3: m1 timed out with error");

    // 4: ack on the final timeout cycle wins
    cyc(); m_req = 4'b0010; mid();
    for (int b = 1; b <= 3; b++) begin
      cyc(); mid();
      check_val($sformatf("t4_b%0d_ack", b), m_ack, 0);
    end
    cyc(); s_ack = 1'b1; s_rdata = 32'hA5A5_0004; mid();
    check_val("t4_b4_ack", m_ack, 4'b0010);
    check_val("t4_b4_err", m_err, 0);
    check_val("t4_b4_rdata", m_rdata, 32'hA5A5_0004);
    cyc(); m_req = '0; s_ack = 1'b0; mid();
    check_val("t4_end_ack", m_ack, 0);
    check_val("t4_end_err", m_err, 0);
    check_val("t4_end_grant", grant, 0);
    $display("txn t4: m1 acked on last timeout cycle");

    // 5: async reset during BUSY of m0, m2 pending
    cyc(); m_req = 4'b0001; m_we = 4'b0001; mid();
    cyc(); m_req = 4'b0101; mid();
    check_val("t5_busy_grant", grant, 4'b0001);
    check_val("t5_busy_hold", hold, 1);
    #1 rst = 1'b0;
    #1;
    check_val("t5_rst_sreq", s_req, 0);
    check_val("t5_rst_grant", grant, 0);
    check_val("t5_rst_hold", hold, 0);
    cyc(); rst = 1'b1; m_req = 4'b0100; m_we = '0; mid();
    check_val("t5_rel_grant", grant, 0);
    cyc(); mid();
    check_val("t5_m2_grant", grant, 4'b0100);
    check_val("t5_m2_sreq", s_req, 1);
    check_val("t5_m2_ack", m_ack, 0);
    cyc(); s_ack = 1'b1; s_rdata = 32'h0000_0055; mid();
    check_val("t5_m2_done", m_ack, 4'b0100);
    cyc(); m_req = '0; s_ack = 1'b0; mid();
    $display("txn t5: m0 abandoned by reset, m2 granted fresh");

    // 6: all four requesting continuously, zero-wait slave
    do_reset();
    m_req = 4'b1111; s_ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      mid();
      check_val($sformatf("t6_%0d_bubble", t), grant, 0);
      cyc(); mid();
      check_val($sformatf("t6_%0d_grant", t), grant, t6_exp[t]);
      check_val($sformatf("t6_%0d_ack", t), m_ack, t6_exp[t]);
      $display("txn t6.%0d: grant 0x%0h", t, grant);
      cyc();
    end
    m_req = '0; s_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
